cd_rx_ram_mp: RTL and testbench
===============================

Name: cd_rx_ram_mp

Overview:
Multi-page receive frame buffer for the CDBUS controller. It is the parametrised successor of the fixed two-page RX RAM.
- Write side: byte-wide, driven by the RX byte assembler, with a per-frame commit via `switch`.
- Read side: 32-bit word-wide, read by the CSR block.
- Completed frames queue in a circular page FIFO of PAGE_NUM pages. The CPU can lag several frames behind the bus without losing any.

Parameters:
PAGE_NUM, 4, total pages (2..16); one page is always owned by the writer, so up to PAGE_NUM-1 frames can queue.
PAGE_AW, 8, byte address width per page (page size 2^PAGE_AW bytes; 256 by default).
CNT_W, $clog2(PAGE_NUM), width of the queued-frame count.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
wr_byte  in  8  byte to store
wr_addr  in  PAGE_AW  byte offset within the current write page
wr_en  in  1  write strobe
wr_len  in  8  frame length, sampled on switch
wr_err  in  1  frame CRC/format error flag, sampled on switch
switch  in  1  one-cycle pulse: commit the current write page as a finished frame
switch_fail  out  1  one-cycle pulse: a frame was lost due to queue full
rd_en  in  1  read enable (RAM power gating)
rd_addr  in  PAGE_AW-2  word offset within the head page
rd_word  out  32  little-endian word from the head page
rd_len  out  8  length of the head frame
rd_err  out  1  error flag of the head frame
rd_done  in  1  one-cycle pulse: release the head frame
rd_done_all  in  1  one-cycle pulse: flush all queued frames
unread  out  1  queue not empty
unread_cnt  out  CNT_W  number of queued frames
unread_len  out  8  equal to rd_len (CSR convenience)

Behaviour:
- Storage:
  - One RAM of PAGE_NUM*2^PAGE_AW bytes, organised as 4 byte lanes.
  - Byte write address is {wp, wr_addr}; lane select is wr_addr[1:0].
  - Read address is {rp, rd_addr}.
- Per-page metadata registers: len[7:0] and err, written only at switch.
- State:
  - wp = write page index; rp = head read page index; cnt = queued frames.
  - Invariant: wp == (rp + cnt) mod PAGE_NUM.
  - Indices wrap modulo PAGE_NUM; non-power-of-two PAGE_NUM is supported via explicit compare-and-clear.
- Reset (clk edge with reset=1): wp=0, rp=0, cnt=0, switch_fail=0, rd_word=0. Metadata is cleared to 0.
- Writes: wr_en stores wr_byte in the same cycle. Writes are never blocked; if the queue is full, the writer still owns page wp.
- Reads:
  - rd_word is registered, with 1-cycle latency after rd_addr while rd_en=1.
  - When rd_en=0, rd_word holds its value and the RAM read port is not clocked.
- Head outputs: rd_len, rd_err and unread_len are combinational from the metadata of page rp. They read 0 when cnt==0.
- unread = (cnt != 0); unread_cnt = cnt.
- Priority each cycle, evaluated in this order:
  1. reset
  2. rd_done_all
  3. rd_done
  4. switch
- rd_done_all: rp <= wp, cnt <= 0. A switch in the same cycle is then evaluated against an empty queue and is accepted.
- rd_done with cnt==0: ignored.
- rd_done with cnt>0: rp <= rp+1, cnt <= cnt-1.
- switch with cnt < PAGE_NUM-1 after applying rd_done:
  - meta[wp] <= {wr_len, wr_err}; wp <= wp+1; cnt <= cnt+1.
  - rd_done and switch together therefore leave cnt unchanged.
- switch with cnt == PAGE_NUM-1 after applying rd_done: frame discarded, wp unchanged, switch_fail=1 for exactly one cycle.
- switch_fail is 0 in every other cycle.
- A write to the page being committed, in the same cycle as switch, lands in the old page.

Optional Feature:
CD_RX_RAM_OVERWRITE_EN
- Defined: a full-queue switch drops the oldest frame instead of the newest.
  - rp <= rp+1, the new frame is committed as normal, wp <= wp+1, cnt stays PAGE_NUM-1.
  - switch_fail still pulses for one cycle to report the lost frame.
- Undefined: behaviour is as described above (the newest frame is discarded).

Test Plan:
- Reset with PAGE_NUM=4: write 3 bytes 0x11,0x22,0x33 at addr 0..2, then switch with wr_len=3, wr_err=0 -> unread=1, unread_cnt=1, rd_len=3. rd_addr=0 gives rd_word=0x??332211 one cycle later.
- Three frames with lengths 5, 6, 7, then rd_done x3 -> rd_len steps 5,6,7 and then 0; unread_cnt steps 3,2,1,0; unread falls after the third rd_done.
- Fourth switch while cnt=3 -> switch_fail high for 1 cycle, cnt stays 3, rd_len still 5. With CD_RX_RAM_OVERWRITE_EN the head becomes 6 and the new frame is queued last.
- cnt=3 with rd_done and switch in the same cycle -> switch_fail=0, cnt=3, new frame becomes the tail.
- Queue holding 2 frames receives rd_done_all and switch together -> cnt=1, head is the new frame.
- Wrap check: commit and release 10 frames in sequence -> indices wrap correctly and data and length match each frame. Repeat with PAGE_NUM=3.
- Assert reset mid-frame (after 2 wr_en, before switch) -> all outputs return to reset values; a subsequent frame is read back correctly from page 0.

Source files
------------

// File: rtl/cd_rx_ram_mp.sv
// Multi-page CDBUS receive frame buffer: byte-wide writer, 32-bit reader, circular page FIFO.
// Optional build macro CD_RX_RAM_OVERWRITE_EN: a full queue drops the oldest frame instead of the newest.
module cd_rx_ram_mp #(
    parameter int PAGE_NUM = 4,
    parameter int PAGE_AW  = 8,
    parameter int CNT_W    = $clog2(PAGE_NUM)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           wr_byte,
    input  logic [PAGE_AW-1:0]   wr_addr,
    input  logic                 wr_en,
    input  logic [7:0]           wr_len,
    input  logic                 wr_err,
    input  logic                 switch,
    output logic                 switch_fail,
    input  logic                 rd_en,
    input  logic [PAGE_AW-3:0]   rd_addr,
    output logic [31:0]          rd_word,
    output logic [7:0]           rd_len,
    output logic                 rd_err,
    input  logic                 rd_done,
    input  logic                 rd_done_all,
    output logic                 unread,
    output logic [CNT_W-1:0]     unread_cnt,
    output logic [7:0]           unread_len
);

    localparam int PW    = $clog2(PAGE_NUM);
    localparam int WAW   = PAGE_AW - 2;
    localparam int DEPTH = PAGE_NUM << WAW;
    localparam logic [PW-1:0]    LAST_PG  = PW'(PAGE_NUM - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PAGE_NUM - 1);

    logic [31:0]       ram [DEPTH];
    logic [31:0]       rd_word_q;
    logic [PW-1:0]     wp_q, wp_d, rp_q, rp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              fail_q, fail_d;
    logic [7:0]        meta_len_q [PAGE_NUM];
    logic [7:0]        meta_len_d [PAGE_NUM];
    logic              meta_err_q [PAGE_NUM];
    logic              meta_err_d [PAGE_NUM];

    // Explicit wrap so non-power-of-two page counts work.
    function automatic logic [PW-1:0] pg_inc(input logic [PW-1:0] p);
        return (p == LAST_PG) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (wr_en)
            ram[{wp_q, wr_addr[PAGE_AW-1:2]}][{wr_addr[1:0], 3'b000} +: 8] <= wr_byte;
    end

    // Read register only loads while rd_en is high so the RAM port can be gated.
    always_ff @(posedge clk) begin
        if (reset)
            rd_word_q <= '0;
        else if (rd_en)
            rd_word_q <= ram[{rp_q, rd_addr}];
    end

    always_comb begin
        rp_d       = rp_q;
        wp_d       = wp_q;
        cnt_d      = cnt_q;
        fail_d     = 1'b0;
        meta_len_d = meta_len_q;
        meta_err_d = meta_err_q;

        if (rd_done_all) begin
            rp_d  = wp_q;
            cnt_d = '0;
        end else if (rd_done && cnt_q != '0) begin
            rp_d  = pg_inc(rp_q);
            cnt_d = cnt_q - 1'b1;
        end

        if (switch) begin
            if (cnt_d != CNT_FULL) begin
                meta_len_d[wp_q] = wr_len;
                meta_err_d[wp_q] = wr_err;
                wp_d             = pg_inc(wp_q);
                cnt_d            = cnt_d + 1'b1;
            end else begin
                fail_d = 1'b1;
`ifdef CD_RX_RAM_OVERWRITE_EN
                rp_d             = pg_inc(rp_d);
                meta_len_d[wp_q] = wr_len;
                meta_err_d[wp_q] = wr_err;
                wp_d             = pg_inc(wp_q);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rp_q   <= '0;
            wp_q   <= '0;
            cnt_q  <= '0;
            fail_q <= 1'b0;
            for (int i = 0; i < PAGE_NUM; i++) begin
                meta_len_q[i] <= '0;
                meta_err_q[i] <= 1'b0;
            end
        end else begin
            rp_q       <= rp_d;
            wp_q       <= wp_d;
            cnt_q      <= cnt_d;
            fail_q     <= fail_d;
            meta_len_q <= meta_len_d;
            meta_err_q <= meta_err_d;
        end
    end

    assign switch_fail = fail_q;
    assign rd_word     = rd_word_q;
    assign unread      = (cnt_q != '0);
    assign unread_cnt  = cnt_q;
    assign rd_len      = unread ? meta_len_q[rp_q] : 8'h00;
    assign rd_err      = unread ? meta_err_q[rp_q] : 1'b0;
    assign unread_len  = rd_len;

endmodule

// File: tb/tb_cd_rx_ram_mp.sv
// Directed bench for cd_rx_ram_mp: a 4-page instance for all scenarios plus a 3-page
// instance sharing inputs for the wrap test.
module tb_cd_rx_ram_mp;

    logic        clk = 1'b0;
    logic        reset, reset3;
    logic [7:0]  wr_byte, wr_len;
    logic [7:0]  wr_addr;
    logic        wr_en, wr_err, switch, rd_en, rd_done, rd_done_all;
    logic [5:0]  rd_addr;

    logic        switch_fail, rd_err, unread;
    logic [31:0] rd_word;
    logic [7:0]  rd_len, unread_len;
    logic [1:0]  unread_cnt;

    logic        switch_fail3, rd_err3, unread3;
    logic [31:0] rd_word3;
    logic [7:0]  rd_len3, unread_len3;
    logic [1:0]  unread_cnt3;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cd_rx_ram_mp #(.PAGE_NUM(4), .PAGE_AW(8)) u_dut4 (
        .clk(clk), .reset(reset), .wr_byte(wr_byte), .wr_addr(wr_addr), .wr_en(wr_en),
        .wr_len(wr_len), .wr_err(wr_err), .switch(switch), .switch_fail(switch_fail),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_word(rd_word), .rd_len(rd_len), .rd_err(rd_err),
        .rd_done(rd_done), .rd_done_all(rd_done_all), .unread(unread),
        .unread_cnt(unread_cnt), .unread_len(unread_len)
    );

    cd_rx_ram_mp #(.PAGE_NUM(3), .PAGE_AW(8)) u_dut3 (
        .clk(clk), .reset(reset3), .wr_byte(wr_byte), .wr_addr(wr_addr), .wr_en(wr_en),
        .wr_len(wr_len), .wr_err(wr_err), .switch(switch), .switch_fail(switch_fail3),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_word(rd_word3), .rd_len(rd_len3), .rd_err(rd_err3),
        .rd_done(rd_done), .rd_done_all(rd_done_all), .unread(unread3),
        .unread_cnt(unread_cnt3), .unread_len(unread_len3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] addr, input logic [7:0] data);
        wr_en = 1'b1; wr_addr = addr; wr_byte = data;
        step();
        wr_en = 1'b0;
    endtask

    task automatic commit(input logic [7:0] len, input logic err);
        switch = 1'b1; wr_len = len; wr_err = err;
        step();
        switch = 1'b0;
    endtask

    // Frame whose first byte is derived from its length, for identifying the head page.
    task automatic frame(input logic [7:0] len, input logic err);
        write_byte(8'd0, len ^ 8'h5A);
        commit(len, err);
    endtask

    task automatic release_head();
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
    endtask

    task automatic read_word(input logic [5:0] addr);
        rd_en = 1'b1; rd_addr = addr;
        step();
        rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  exp_len [3];
        logic        exp_err [3];
        logic [31:0] exp_word;

        reset = 1'b1; reset3 = 1'b1;
        wr_byte = '0; wr_addr = '0; wr_en = 0; wr_len = '0; wr_err = 0;
        switch = 0; rd_en = 0; rd_addr = '0; rd_done = 0; rd_done_all = 0;
        step(); step();
        reset = 1'b0;

        check("rst_unread", unread, 0);
        check("rst_cnt", unread_cnt, 0);
        check("rst_len", rd_len, 0);
        check("rst_err", rd_err, 0);
        check("rst_fail", switch_fail, 0);
        check("rst_word", rd_word, 0);

        // First frame: three bytes, little-endian word readback
        write_byte(8'd0, 8'h11);
        write_byte(8'd1, 8'h22);
        write_byte(8'd2, 8'h33);
        commit(8'd3, 1'b0);
        check("f1_fail", switch_fail, 0);
        check("f1_unread", unread, 1);
        check("f1_cnt", unread_cnt, 1);
        check("f1_len", rd_len, 3);
        check("f1_ulen", unread_len, 3);
        read_word(6'd0);
        check("f1_word", rd_word & 32'h00FF_FFFF, 32'h0033_2211);
        rd_addr = 6'd5;
        step();
        check("f1_hold", rd_word & 32'h00FF_FFFF, 32'h0033_2211);
        release_head();
        check("f1_rel_cnt", unread_cnt, 0);
        check("f1_rel_len", rd_len, 0);

        // Fill to PAGE_NUM-1 then overflow
        frame(8'd5, 1'b0);
        frame(8'd6, 1'b1);
        frame(8'd7, 1'b0);
        check("q3_cnt", unread_cnt, 3);
        check("q3_len", rd_len, 5);
        frame(8'd8, 1'b0);
        check("full_fail", switch_fail, 1);
        check("full_cnt", unread_cnt, 3);
`ifdef CD_RX_RAM_OVERWRITE_EN
        exp_len = '{8'd6, 8'd7, 8'd8};
        exp_err = '{1'b1, 1'b0, 1'b0};
`else
        exp_len = '{8'd5, 8'd6, 8'd7};
        exp_err = '{1'b0, 1'b1, 1'b0};
`endif
        check("full_head", rd_len, exp_len[0]);
        step();
        check("full_fail_clr", switch_fail, 0);
        for (int k = 0; k < 3; k++) begin
            read_word(6'd0);
            check("drain_data", rd_word & 32'hFF, {24'h0, exp_len[k] ^ 8'h5A});
            check("drain_len", rd_len, exp_len[k]);
            check("drain_err", rd_err, exp_err[k]);
            release_head();
            check("drain_cnt", unread_cnt, 2 - k);
        end
        check("drain_unread", unread, 0);
        check("drain_len0", rd_len, 0);

        // Full queue with rd_done + switch (and a write into the committing page) together
        frame(8'h10, 1'b0);
        frame(8'h11, 1'b0);
        frame(8'h12, 1'b0);
        wr_en = 1'b1; wr_addr = 8'd0; wr_byte = 8'h13 ^ 8'h5A;
        rd_done = 1'b1; switch = 1'b1; wr_len = 8'h13; wr_err = 1'b0;
        step();
        wr_en = 1'b0; rd_done = 1'b0; switch = 1'b0;
        check("both_fail", switch_fail, 0);
        check("both_cnt", unread_cnt, 3);
        check("both_head", rd_len, 8'h11);
        for (int k = 0; k < 3; k++) begin
            read_word(6'd0);
            check("both_data", rd_word & 32'hFF, {24'h0, (8'h11 + 8'(k)) ^ 8'h5A});
            check("both_len", rd_len, 8'h11 + 8'(k));
            release_head();
        end
        check("both_empty", unread_cnt, 0);

        // rd_done on empty queue is ignored
        release_head();
        check("empty_done_cnt", unread_cnt, 0);
        frame(8'h20, 1'b0);
        check("empty_done_head", rd_len, 8'h20);
        frame(8'h21, 1'b0);
        write_byte(8'd0, 8'h22 ^ 8'h5A);
        rd_done_all = 1'b1; switch = 1'b1; wr_len = 8'h22; wr_err = 1'b1;
        step();
        rd_done_all = 1'b0; switch = 1'b0;
        check("flush_fail", switch_fail, 0);
        check("flush_cnt", unread_cnt, 1);
        check("flush_len", rd_len, 8'h22);
        check("flush_ulen", unread_len, 8'h22);
        check("flush_err", rd_err, 1);
        read_word(6'd0);
        check("flush_data", rd_word & 32'hFF, {24'h0, 8'h22 ^ 8'h5A});
        release_head();
        check("flush_rel", unread_cnt, 0);

        // Reset in the middle of a frame
        write_byte(8'd0, 8'h99);
        write_byte(8'd1, 8'h98);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_word", rd_word, 0);
        check("mid_cnt", unread_cnt, 0);
        check("mid_unread", unread, 0);
        check("mid_len", rd_len, 0);
        check("mid_fail", switch_fail, 0);
        write_byte(8'd0, 8'h44);
        write_byte(8'd1, 8'h55);
        write_byte(8'd2, 8'h66);
        write_byte(8'd3, 8'h77);
        commit(8'd4, 1'b1);
        check("mid2_len", rd_len, 4);
        check("mid2_err", rd_err, 1);
        read_word(6'd0);
        check("mid2_word", rd_word, 32'h7766_5544);

        // Wrap: 10 frames through both the 4-page and 3-page instances
        reset = 1'b1; reset3 = 1'b1;
        step();
        reset = 1'b0; reset3 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            for (int b = 0; b < 4; b++)
                write_byte(8'(4 + b), 8'(i * 16 + b));
            commit(8'(i + 1), 1'(i % 2));
            exp_word = {8'(i * 16 + 3), 8'(i * 16 + 2), 8'(i * 16 + 1), 8'(i * 16)};
            check("wrap4_cnt", unread_cnt, 1);
            check("wrap3_cnt", unread_cnt3, 1);
            check("wrap4_len", rd_len, i + 1);
            check("wrap3_len", rd_len3, i + 1);
            check("wrap3_err", rd_err3, i % 2);
            read_word(6'd1);
            check("wrap4_word", rd_word, exp_word);
            check("wrap3_word", rd_word3, exp_word);
            release_head();
            check("wrap4_rel", unread_cnt, 0);
            check("wrap3_rel", unread_cnt3, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
